// File: rtl/plic_round_max_arb_if.sv
// Controller <-> per-hart max-priority arbiter bundle: request/priority space,
// round control and the winning source returned to the controller.
interface plic_round_max_arb_if #(
    parameter int unsigned PRIO_BIT = 5,
    parameter int unsigned ECH_RD   = 32,
    parameter int unsigned ID_BIT   = 10
);
    localparam int unsigned SRC_NUM = 32'(1) << ID_BIT;
    localparam int unsigned KEY_W   = PRIO_BIT + 1;
    localparam int unsigned RND_W   = ID_BIT - $clog2(ECH_RD);

    logic [SRC_NUM-1:0]       ctrl_arb_int_req;
    logic [SRC_NUM*KEY_W-1:0] ctrl_arb_int_prio;
    logic [RND_W-1:0]         ctrl_arb_select_round;
    logic                     ctrl_arb_round_vld;
    logic                     ctrl_arb_new_arb_start;
    logic                     hreg_arbx_arb_flush;
    logic                     arb_ctrl_int_req;
    logic [KEY_W-1:0]         arb_ctrl_int_prio;
    logic [ID_BIT-1:0]        arb_ctrl_int_id;

    modport master (
        output ctrl_arb_int_req, ctrl_arb_int_prio, ctrl_arb_select_round,
               ctrl_arb_round_vld, ctrl_arb_new_arb_start, hreg_arbx_arb_flush,
        input  arb_ctrl_int_req, arb_ctrl_int_prio, arb_ctrl_int_id
    );

    modport slave (
        input  ctrl_arb_int_req, ctrl_arb_int_prio, ctrl_arb_select_round,
               ctrl_arb_round_vld, ctrl_arb_new_arb_start, hreg_arbx_arb_flush,
        output arb_ctrl_int_req, arb_ctrl_int_prio, arb_ctrl_int_id
    );
endinterface

// File: rtl/plic_round_max_arb.sv
// Per-hart multi-round max-priority arbiter: one ECH_RD-wide slice per round,
// folded into a running best; lowest ID wins ties, source 0 never wins.
module plic_round_max_arb #(
    parameter int unsigned PRIO_BIT = 5,
    parameter int unsigned ECH_RD   = 32,
    parameter int unsigned ID_BIT   = 10
) (
    input logic                  plic_clk,
    input logic                  plicrst_b,
    plic_round_max_arb_if.slave  arb
);
    localparam int unsigned KEY_W   = PRIO_BIT + 1;
    localparam int unsigned LIDX_W  = $clog2(ECH_RD);
    localparam int unsigned RND_W   = ID_BIT - LIDX_W;
    localparam int unsigned SLICE_W = ECH_RD * KEY_W;

    logic [ID_BIT-1:0]  base_id;
    logic [31:0]        prio_base;
    logic [ECH_RD-1:0]  slice_req;
    logic [SLICE_W-1:0] slice_prio;

    logic               sl_found;
    logic [KEY_W-1:0]   sl_key;
    logic [LIDX_W-1:0]  sl_idx;
    logic [KEY_W-1:0]   cur_key;
    logic               cur_elig;

    logic               s1_vld;
    logic               s1_start;
    logic               s1_req;
    logic [KEY_W-1:0]   s1_key;
    logic [ID_BIT-1:0]  s1_id;

    logic               best_req;
    logic [KEY_W-1:0]   best_key;
    logic [ID_BIT-1:0]  best_id;
    logic               best_load;

    // Slice of the padded source space addressed by the current round
    assign base_id    = {arb.ctrl_arb_select_round, LIDX_W'(0)};
    assign prio_base  = 32'(base_id) * 32'(KEY_W);
    assign slice_req  = arb.ctrl_arb_int_req[base_id +: ECH_RD];
    assign slice_prio = arb.ctrl_arb_int_prio[prio_base +: SLICE_W];

    // Slice max; strict compare while scanning upward keeps the lowest index
    always_comb begin
        sl_found = 1'b0;
        sl_key   = '0;
        sl_idx   = '0;
        cur_key  = '0;
        cur_elig = 1'b0;
        for (int unsigned j = 0; j < ECH_RD; j++) begin
            cur_key  = slice_prio[j*KEY_W +: KEY_W];
            cur_elig = slice_req[j] && (cur_key[PRIO_BIT-1:0] != '0) &&
                       !((base_id == '0) && (j == 0));
            if (cur_elig && (!sl_found || (cur_key > sl_key))) begin
                sl_found = 1'b1;
                sl_key   = cur_key;
                sl_idx   = LIDX_W'(j);
            end
        end
    end

    always_ff @(posedge plic_clk or negedge plicrst_b) begin
        if (!plicrst_b) begin
            s1_vld   <= 1'b0;
            s1_start <= 1'b0;
            s1_req   <= 1'b0;
            s1_key   <= '0;
            s1_id    <= '0;
        end else if (arb.hreg_arbx_arb_flush) begin
            s1_vld   <= 1'b0;
            s1_start <= 1'b0;
            s1_req   <= 1'b0;
            s1_key   <= '0;
            s1_id    <= '0;
        end else if (arb.ctrl_arb_round_vld) begin
            s1_vld   <= 1'b1;
            s1_start <= arb.ctrl_arb_new_arb_start;
            s1_req   <= sl_found;
            s1_key   <= sl_key;
            s1_id    <= {arb.ctrl_arb_select_round, sl_idx};
        end else begin
            s1_vld   <= 1'b0;
        end
    end

    // Start round reloads unconditionally so a stale winner never survives
    assign best_load = s1_vld &&
                       (s1_start || (s1_req && (!best_req || (s1_key > best_key))));

    always_ff @(posedge plic_clk or negedge plicrst_b) begin
        if (!plicrst_b) begin
            best_req <= 1'b0;
            best_key <= '0;
            best_id  <= '0;
        end else if (arb.hreg_arbx_arb_flush) begin
            best_req <= 1'b0;
            best_key <= '0;
            best_id  <= '0;
        end else if (best_load) begin
            best_req <= s1_req;
            best_key <= s1_key;
            best_id  <= s1_id;
        end
    end

    assign arb.arb_ctrl_int_req  = best_req;
    assign arb.arb_ctrl_int_prio = best_key;
    assign arb.arb_ctrl_int_id   = best_id;

    logic unused_rnd;
    assign unused_rnd = ^{RND_W'(0)};
endmodule

// File: tb/tb_plic_round_max_arb.sv
// Directed bench for plic_round_max_arb: full 32-round arbitrations with
// hand-computed winners, flush and async reset mid-arbitration.
module tb_plic_round_max_arb;
    localparam int unsigned PRIO_BIT = 5;
    localparam int unsigned ECH_RD   = 32;
    localparam int unsigned ID_BIT   = 10;
    localparam int unsigned KEY_W    = PRIO_BIT + 1;

    logic plic_clk;
    logic plicrst_b;
    int   checks;
    int   failures;
    logic early_req;

    plic_round_max_arb_if #(.PRIO_BIT(PRIO_BIT), .ECH_RD(ECH_RD), .ID_BIT(ID_BIT)) arb_if ();

    plic_round_max_arb #(.PRIO_BIT(PRIO_BIT), .ECH_RD(ECH_RD), .ID_BIT(ID_BIT)) dut (
        .plic_clk  (plic_clk),
        .plicrst_b (plicrst_b),
        .arb       (arb_if)
    );

    initial plic_clk = 1'b0;
    always #5 plic_clk = ~plic_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rq, input logic [KEY_W-1:0] key,
                           input logic [ID_BIT-1:0] id);
        chk({tag, "_req"},  32'(arb_if.arb_ctrl_int_req),  32'(rq));
        chk({tag, "_prio"}, 32'(arb_if.arb_ctrl_int_prio), 32'(key));
        chk({tag, "_id"},   32'(arb_if.arb_ctrl_int_id),   32'(id));
    endtask

    task automatic clr_srcs();
        arb_if.ctrl_arb_int_req  = '0;
        arb_if.ctrl_arb_int_prio = '0;
    endtask

    task automatic set_src(input int id, input logic [KEY_W-1:0] key, input logic rq);
        arb_if.ctrl_arb_int_req[id]                 = rq;
        arb_if.ctrl_arb_int_prio[id*KEY_W +: KEY_W] = key;
    endtask

    // Rounds 0..31 with start on round 0; returns sampled at t+2 of round 31
    task automatic run_arb();
        for (int r = 0; r < 32; r++) begin
            @(negedge plic_clk);
            arb_if.ctrl_arb_select_round  = 5'(r);
            arb_if.ctrl_arb_round_vld     = 1'b1;
            arb_if.ctrl_arb_new_arb_start = (r == 0);
        end
        @(posedge plic_clk);
        #1 early_req = arb_if.arb_ctrl_int_req;
        @(negedge plic_clk);
        arb_if.ctrl_arb_round_vld     = 1'b0;
        arb_if.ctrl_arb_new_arb_start = 1'b0;
        @(posedge plic_clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        early_req = 1'b0;
        plicrst_b = 1'b0;
        clr_srcs();
        arb_if.ctrl_arb_select_round  = '0;
        arb_if.ctrl_arb_round_vld     = 1'b0;
        arb_if.ctrl_arb_new_arb_start = 1'b0;
        arb_if.hreg_arbx_arb_flush    = 1'b0;
        repeat (2) @(negedge plic_clk);
        chk_out("reset", 1'b0, 6'h00, 10'd0);
        plicrst_b = 1'b1;

        set_src(37, 6'h05, 1'b1);
        run_arb();
        chk_out("single37", 1'b1, 6'h05, 10'd37);

        clr_srcs();
        set_src(3, 6'h04, 1'b1);
        set_src(600, 6'h07, 1'b1);
        run_arb();
        chk_out("cross600", 1'b1, 6'h07, 10'd600);

        clr_srcs();
        set_src(3, 6'h07, 1'b1);
        set_src(600, 6'h04, 1'b1);
        run_arb();
        chk_out("cross3", 1'b1, 6'h07, 10'd3);

        clr_srcs();
        set_src(40, 6'h06, 1'b1);
        set_src(41, 6'h06, 1'b1);
        set_src(900, 6'h06, 1'b1);
        run_arb();
        chk_out("tie40", 1'b1, 6'h06, 10'd40);

        clr_srcs();
        set_src(10, 6'h1F, 1'b1);
        set_src(500, 6'h21, 1'b1);
        run_arb();
        chk_out("mode500", 1'b1, 6'h21, 10'd500);

        // Start without round_vld must not disturb the held winner
        @(negedge plic_clk);
        arb_if.ctrl_arb_new_arb_start = 1'b1;
        repeat (2) @(negedge plic_clk);
        arb_if.ctrl_arb_new_arb_start = 1'b0;
        chk_out("start_novld", 1'b1, 6'h21, 10'd500);

        clr_srcs();
        set_src(0, 6'h1F, 1'b1);
        set_src(7, 6'h20, 1'b1);
        set_src(8, 6'h1F, 1'b0);
        run_arb();
        chk_out("excl", 1'b0, 6'h00, 10'd0);

        // Highest ID in the last round: not visible at t+1, visible at t+2
        clr_srcs();
        set_src(1023, 6'h02, 1'b1);
        run_arb();
        chk("lat_t1_req", 32'(early_req), 32'd0);
        chk_out("top1023", 1'b1, 6'h02, 10'd1023);

        // Flush at round 12 with a pending winner
        clr_srcs();
        set_src(37, 6'h05, 1'b1);
        for (int r = 0; r <= 12; r++) begin
            @(negedge plic_clk);
            arb_if.ctrl_arb_select_round  = 5'(r);
            arb_if.ctrl_arb_round_vld     = 1'b1;
            arb_if.ctrl_arb_new_arb_start = (r == 0);
            arb_if.hreg_arbx_arb_flush    = (r == 12);
        end
        #1 chk("flush_pending_req", 32'(arb_if.arb_ctrl_int_req), 32'd1);
        @(posedge plic_clk);
        #1 chk_out("flush", 1'b0, 6'h00, 10'd0);
        @(negedge plic_clk);
        arb_if.hreg_arbx_arb_flush = 1'b0;
        arb_if.ctrl_arb_round_vld  = 1'b0;
        @(posedge plic_clk);
        #1 chk("flush_hold_req", 32'(arb_if.arb_ctrl_int_req), 32'd0);
        run_arb();
        chk_out("flush_rerun", 1'b1, 6'h05, 10'd37);

        // Async reset mid-arbitration
        clr_srcs();
        set_src(600, 6'h07, 1'b1);
        for (int r = 0; r <= 20; r++) begin
            @(negedge plic_clk);
            arb_if.ctrl_arb_select_round  = 5'(r);
            arb_if.ctrl_arb_round_vld     = 1'b1;
            arb_if.ctrl_arb_new_arb_start = (r == 0);
        end
        #2 chk("rst_pending_req", 32'(arb_if.arb_ctrl_int_req), 32'd1);
        plicrst_b = 1'b0;
        #1 chk_out("async_rst", 1'b0, 6'h00, 10'd0);
        @(negedge plic_clk);
        arb_if.ctrl_arb_round_vld     = 1'b0;
        arb_if.ctrl_arb_new_arb_start = 1'b0;
        plicrst_b = 1'b1;
        @(posedge plic_clk);
        #1 chk("rst_hold_req", 32'(arb_if.arb_ctrl_int_req), 32'd0);
        run_arb();
        chk_out("rst_rerun", 1'b1, 6'h07, 10'd600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plic_round_max_arb.md
Name: plic_round_max_arb

Overview:
- Per-hart, multi-round maximum-priority arbiter. It sits directly upstream of the per-hart arbitration controller.
- It consumes the controller's padded 1024-bit request vector, the per-source {mmode,prio} fields and the round select.
- Each round it finds the best source in one ECH_RD-wide slice and folds it into a running best.
- It returns the winning request, mode+priority and source ID to the controller in time for its WRITE_CLAIM state.

Parameters:
- PRIO_BIT, 5, width of the priority value; each source field is PRIO_BIT+1 bits with the mmode bit as MSB.
- ECH_RD, 32, sources examined per round; fixed at 32 for the 1024-source padded space.
- ID_BIT, 10, width of the winning source ID.

Ports:
- plic_clk  in  1  gated arbitration clock from the controller (arb_clk).
- plicrst_b  in  1  asynchronous active-low reset.
- ctrl_arb_int_req  in  1024  masked, padded request vector.
- ctrl_arb_int_prio  in  1024*(PRIO_BIT+1)  per-source {mmode,prio}.
- ctrl_arb_select_round  in  5  slice index; the slice is sources [32*r +: 32].
- ctrl_arb_round_vld  in  1  controller is in ARBTRATE this cycle.
- ctrl_arb_new_arb_start  in  1  first ARBTRATE cycle (round 0).
- hreg_arbx_arb_flush  in  1  synchronous abort.
- arb_ctrl_int_req  out  1  a winner exists.
- arb_ctrl_int_prio  out  PRIO_BIT+1  winner {mmode,prio}.
- arb_ctrl_int_id  out  ID_BIT  winner source ID; consumed by the claim register.

Behaviour:
- Eligibility: source i is eligible iff req[i]=1, prio[PRIO_BIT-1:0]!=0 and i!=0. ID 0 is never a winner.
- Compare key: the full PRIO_BIT+1 field, unsigned. An M-mode source (MSB=1) therefore beats any S-mode source.
- Stage 0 (combinational): select the 32-source slice by ctrl_arb_select_round.
  - Compute the slice max key among eligible sources.
  - Ties go to the lowest ID.
  - Slice ID = {round, 5-bit local index}.
- Stage 1 registers, written on every clock where ctrl_arb_round_vld=1:
  - s1_vld = round_vld.
  - s1_start = new_arb_start.
  - s1_req = any eligible in slice.
  - s1_key and s1_id from the slice result.
  - When round_vld=0: s1_vld<=0 and the other stage-1 fields hold.
- Stage 2, running best {best_req, best_key, best_id}, written when s1_vld=1:
  - If s1_start=1: load s1 unconditionally (including s1_req=0, which clears best_req).
  - Else if s1_req and (!best_req or s1_key > best_key): load s1.
  - Else hold.
  - The comparison is strictly greater, so an earlier (lower-ID) round keeps equal keys. Global tie-break is lowest ID.
- Outputs are driven directly from the best registers.
- Latency: round r presented in cycle t is reflected in the outputs at t+2.
  - With the last round in the final ARBTRATE cycle, the result is visible in WRITE_CLAIM (after ARB_DELAY).
- Outputs hold after the last round until the next s1_start. The controller samples them only in WRITE_CLAIM.
- Flush: on the next edge, all stage-1 and stage-2 registers clear to 0. It takes priority over round_vld and start in the same cycle.
- new_arb_start without round_vld is ignored.
- A round presented again (same r) is idempotent under max.
- Reset: all registers 0.
  - arb_ctrl_int_req=0, arb_ctrl_int_prio=0, arb_ctrl_int_id=0.
  - Reset mid-arbitration discards partial results.
- Width rules:
  - ID is formed by concatenation with no arithmetic overflow.
  - Round values ≥ RD_NUM carry only padded zero requests, so they yield s1_req=0.
- Clock-gating note: plic_clk stops when the controller is idle. No behaviour may depend on free-running cycles.

Test Plan:
- Single source: req[37]=1, prio=5, mmode=0, rounds 0..31 with start at round 0 → WRITE_CLAIM cycle shows req=1, prio=6'h05, id=37.
- Cross-round max: src 3 prio 4 (round 0) and src 600 prio 7 (round 18) → id=600, prio=6'h07. Swapping the priorities → id=3.
- Tie-break: src 40 and src 900 both prio 6, plus src 41 prio 6 in the same slice as 40 → id=40.
- Mode dominance: src 10 S prio 31 and src 500 M prio 1 → prio=6'h21, id=500.
- Exclusions: src 0 req=1 prio 31, src 7 prio 0, nothing else → req=0, id=0. A new start after a previous win clears the stale winner.
- Flush/reset: assert hreg_arbx_arb_flush at round 12 with a winner pending → next cycle all outputs 0, and a restarted full arbitration gives the correct winner. Async plicrst_b low mid-round → outputs 0 immediately.
